// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_ctrl_pkg : shared constants for the pipeline sequencer        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package pipe_ctrl_pkg;

  localparam logic [1:0] ST_RUN   = 2'b00;
  localparam logic [1:0] ST_HALT  = 2'b01;
  localparam logic [1:0] ST_STEP  = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage
`default_nettype wire

// File: rtl/step_sync.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | step_sync : button synchronizer with single-cycle rising pulse     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module step_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic step_req,
  output logic step_pulse
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  generate
    if (SYNC_STAGES == 1) begin : g_single
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_sync <= '0;
        else       r_sync <= step_req;
      end
    end else begin : g_chain
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_sync <= '0;
        else       r_sync <= {r_sync[SYNC_STAGES-2:0], step_req};
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_prev <= 1'b0;
    else       r_prev <= r_sync[SYNC_STAGES-1];
  end

  // A held button yields one pulse: only the 0->1 transition is reported.
  assign step_pulse = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_hazard_ctrl : run/halt/step FSM, hazard enables and counters  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int START_RUN   = 1,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       idex_rd,
  input  logic             idex_memread,
  input  logic             exmem_redirect,
  input  logic             run_en,
  input  logic             step_req,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             pipe_en,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] RESET_STATE = (START_RUN != 0) ? ST_RUN : ST_HALT;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic             w_step_pulse;
  logic             w_adv;
  logic             w_lu;
  logic             w_stall;
  logic             w_flush;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  step_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_step_sync (
    .clk        (clk),
    .rstn       (rstn),
    .step_req   (step_req),
    .step_pulse (w_step_pulse)
  );

  always_comb begin
    w_next_state = ST_HALT;
    case (r_state)
      ST_RUN:  w_next_state = run_en ? ST_RUN : ST_HALT;
      ST_HALT: begin
        if (run_en)            w_next_state = ST_RUN;
        else if (w_step_pulse) w_next_state = ST_STEP;
        else                   w_next_state = ST_HALT;
      end
      ST_STEP: w_next_state = run_en ? ST_RUN : ST_HALT;
      default: w_next_state = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= RESET_STATE;
    else       r_state <= w_next_state;
  end

  // Gating with rstn keeps every enable low while reset is held.
  assign w_adv = rstn & ((r_state == ST_RUN) | (r_state == ST_STEP));

  assign w_lu = idex_memread & (idex_rd != REG_ZERO) &
                ((id_use_rs1 & (id_rs1 == idex_rd)) |
                 (id_use_rs2 & (id_rs2 == idex_rd)));

  // A redirect squashes the load-use pair, so it outranks the stall.
  assign w_flush = w_adv & exmem_redirect;
  assign w_stall = w_adv & w_lu & ~exmem_redirect;

  always_comb begin
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    pipe_en     = 1'b0;
    if (w_flush) begin
      pc_we       = 1'b1;
      ifid_we     = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      pipe_en     = 1'b1;
    end else if (w_stall) begin
      idex_flush  = 1'b1;
      pipe_en     = 1'b1;
    end else if (w_adv) begin
      pc_we       = 1'b1;
      ifid_we     = 1'b1;
      pipe_en     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign state_o   = r_state;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// Directed bench for pipe_hazard_ctrl; a second narrow-counter instance
// starting in HALT covers the reset state option and counter saturation.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic [4:0] id_rs1, id_rs2, idex_rd;
  logic       id_use_rs1, id_use_rs2, idex_memread, exmem_redirect;
  logic       run_en, step_req;

  logic        pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush, pipe_en;
  logic [1:0]  state_o;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_pc_we, s_ifid_we, s_ifid_flush, s_idex_flush, s_exmem_flush, s_pipe_en;
  logic [1:0]  s_state;
  logic [2:0]  s_stall_cnt, s_flush_cnt;

  logic [5:0]  outs;
  int vectors = 0;
  int miscompares = 0;

  // {pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush, pipe_en}
  localparam logic [5:0] O_RUN    = 6'b110001;
  localparam logic [5:0] O_STALL  = 6'b000101;
  localparam logic [5:0] O_FLUSH  = 6'b111111;
  localparam logic [5:0] O_FROZEN = 6'b000000;

  assign outs = {pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush, pipe_en};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.START_RUN(1), .CNT_W(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rstn(rstn), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .idex_rd(idex_rd),
    .idex_memread(idex_memread), .exmem_redirect(exmem_redirect),
    .run_en(run_en), .step_req(step_req), .pc_we(pc_we), .ifid_we(ifid_we),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .pipe_en(pipe_en), .state_o(state_o), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.START_RUN(0), .CNT_W(3), .SYNC_STAGES(2)) dut_small (
    .clk(clk), .rstn(rstn), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .idex_rd(idex_rd),
    .idex_memread(idex_memread), .exmem_redirect(exmem_redirect),
    .run_en(run_en), .step_req(step_req), .pc_we(s_pc_we), .ifid_we(s_ifid_we),
    .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush), .exmem_flush(s_exmem_flush),
    .pipe_en(s_pipe_en), .state_o(s_state), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_hazards();
    id_rs1 = 5'd0; id_rs2 = 5'd0; idex_rd = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    idex_memread = 1'b0; exmem_redirect = 1'b0;
  endtask

  task automatic test_reset();
    clear_hazards();
    run_en = 1'b1; step_req = 1'b0; rstn = 1'b0;
    #12;
    vectors++; if (outs !== O_FROZEN) begin miscompares++; $display("FAIL reset_outs: got %b want %b", outs, O_FROZEN); end
    vectors++; if (state_o !== 2'b00) begin miscompares++; $display("FAIL reset_state: got %b want 00", state_o); end
    vectors++; if (s_state !== 2'b01) begin miscompares++; $display("FAIL reset_state_halt: got %b want 01", s_state); end
    vectors++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_cnts: got %h/%h want 0/0", stall_cnt, flush_cnt); end
    @(negedge clk); rstn = 1'b1;
    #1;
    vectors++; if (outs !== O_RUN) begin miscompares++; $display("FAIL run_outs: got %b want %b", outs, O_RUN); end
    tick();
    vectors++; if (s_state !== 2'b00) begin miscompares++; $display("FAIL halt_to_run: got %b want 00", s_state); end
  endtask

  task automatic test_load_use();
    idex_memread = 1'b1; idex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
    #1;
    vectors++; if (outs !== O_STALL) begin miscompares++; $display("FAIL lu_rs2_outs: got %b want %b", outs, O_STALL); end
    tick();
    vectors++; if (stall_cnt !== 16'd1) begin miscompares++; $display("FAIL lu_rs2_cnt: got %0d want 1", stall_cnt); end
    // rs1 match while the instruction does not claim rs1: no stall
    clear_hazards();
    idex_memread = 1'b1; idex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b0;
    #1;
    vectors++; if (outs !== O_RUN) begin miscompares++; $display("FAIL lu_unused_outs: got %b want %b", outs, O_RUN); end
    id_use_rs1 = 1'b1;
    #1;
    vectors++; if (outs !== O_STALL) begin miscompares++; $display("FAIL lu_rs1_outs: got %b want %b", outs, O_STALL); end
    tick();
    clear_hazards();
    #1;
    vectors++; if (stall_cnt !== 16'd2) begin miscompares++; $display("FAIL lu_rs1_cnt: got %0d want 2", stall_cnt); end
    vectors++; if (outs !== O_RUN) begin miscompares++; $display("FAIL lu_release: got %b want %b", outs, O_RUN); end
  endtask

  task automatic test_rd_zero();
    idex_memread = 1'b1; idex_rd = 5'd0; id_rs2 = 5'd0; id_use_rs2 = 1'b1;
    id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    #1;
    vectors++; if (outs !== O_RUN) begin miscompares++; $display("FAIL rd0_outs: got %b want %b", outs, O_RUN); end
    tick();
    clear_hazards();
    vectors++; if (stall_cnt !== 16'd2) begin miscompares++; $display("FAIL rd0_cnt: got %0d want 2", stall_cnt); end
  endtask

  task automatic test_redirect();
    idex_memread = 1'b1; idex_rd = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 1'b1;
    exmem_redirect = 1'b1;
    #1;
    vectors++; if (outs !== O_FLUSH) begin miscompares++; $display("FAIL redir_outs: got %b want %b", outs, O_FLUSH); end
    tick();
    clear_hazards();
    vectors++; if (flush_cnt !== 16'd1) begin miscompares++; $display("FAIL redir_flush_cnt: got %0d want 1", flush_cnt); end
    vectors++; if (stall_cnt !== 16'd2) begin miscompares++; $display("FAIL redir_stall_cnt: got %0d want 2", stall_cnt); end
    vectors++; if (s_flush_cnt !== 3'd1) begin miscompares++; $display("FAIL redir_small_cnt: got %0d want 1", s_flush_cnt); end
  endtask

  task automatic test_step();
    int en_cycles;
    int step_cycles;
    int run_shape;
    run_en = 1'b0;
    tick();
    vectors++; if (state_o !== 2'b01 || outs !== O_FROZEN) begin miscompares++; $display("FAIL halt_entry: got st=%b o=%b want st=01 o=%b", state_o, outs, O_FROZEN); end
    // hazards arriving while halted must neither enable nor count
    exmem_redirect = 1'b1; idex_memread = 1'b1; idex_rd = 5'd3; id_rs2 = 5'd3; id_use_rs2 = 1'b1;
    #1;
    vectors++; if (outs !== O_FROZEN) begin miscompares++; $display("FAIL halt_frozen: got %b want %b", outs, O_FROZEN); end
    tick();
    vectors++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd2) begin miscompares++; $display("FAIL halt_cnts: got %0d/%0d want 2/1", stall_cnt, flush_cnt); end
    clear_hazards();
    step_req = 1'b1;
    en_cycles = 0; step_cycles = 0; run_shape = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (pipe_en === 1'b1) en_cycles++;
      if (state_o === 2'b10) step_cycles++;
      if (state_o === 2'b10 && outs === O_RUN) run_shape++;
    end
    vectors++; if (en_cycles !== 1) begin miscompares++; $display("FAIL step_en_cycles: got %0d want 1", en_cycles); end
    vectors++; if (step_cycles !== 1 || run_shape !== 1) begin miscompares++; $display("FAIL step_state_cycles: got %0d/%0d want 1/1", step_cycles, run_shape); end
    vectors++; if (state_o !== 2'b01 || outs !== O_FROZEN) begin miscompares++; $display("FAIL step_return: got st=%b o=%b want st=01 o=%b", state_o, outs, O_FROZEN); end
    step_req = 1'b0; run_en = 1'b1;
    tick();
    vectors++; if (state_o !== 2'b00 || outs !== O_RUN) begin miscompares++; $display("FAIL step_resume: got st=%b o=%b want st=00 o=%b", state_o, outs, O_RUN); end
  endtask

  task automatic test_saturation();
    idex_memread = 1'b1; idex_rd = 5'd12; id_rs2 = 5'd12; id_use_rs2 = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    vectors++; if (s_stall_cnt !== 3'd6) begin miscompares++; $display("FAIL sat_mid: got %0d want 6", s_stall_cnt); end
    for (int i = 0; i < 6; i++) tick();
    vectors++; if (s_stall_cnt !== 3'd7) begin miscompares++; $display("FAIL sat_hold: got %0d want 7", s_stall_cnt); end
    vectors++; if (stall_cnt !== 16'd12) begin miscompares++; $display("FAIL sat_wide: got %0d want 12", stall_cnt); end
  endtask

  task automatic test_async_reset();
    // mid-stall: reset lands between clock edges
    #2;
    rstn = 1'b0;
    #1;
    vectors++; if (outs !== O_FROZEN) begin miscompares++; $display("FAIL areset_outs: got %b want %b", outs, O_FROZEN); end
    vectors++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || s_stall_cnt !== 3'd0) begin miscompares++; $display("FAIL areset_cnts: got %0d/%0d/%0d want 0/0/0", stall_cnt, flush_cnt, s_stall_cnt); end
    vectors++; if (state_o !== 2'b00 || s_state !== 2'b01) begin miscompares++; $display("FAIL areset_state: got %b/%b want 00/01", state_o, s_state); end
    clear_hazards();
    @(negedge clk); rstn = 1'b1;
    tick();
    vectors++; if (outs !== O_RUN || stall_cnt !== 16'd0) begin miscompares++; $display("FAIL areset_release: got o=%b c=%0d want o=%b c=0", outs, stall_cnt, O_RUN); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_rd_zero();
    test_redirect();
    test_step();
    test_saturation();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
